// File: rtl/hamming_pkg.sv
// hamming_pkg: FSM state type, popcount mode constants and counter width helper
package hamming_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  localparam int MODE_XOR = 0;
  localparam int MODE_XNOR = 1;
  function automatic int cnt_w(input int cc);
    return cc > 1 ? $clog2(cc) : 1;
  endfunction
endpackage

// File: rtl/hamming_seq_acc_if.sv
// hamming_seq_acc_if: start/beat/threshold inputs and busy/done/o/o_ge results; master drives beats, slave is the engine
interface hamming_seq_acc_if #(parameter int W = 5, parameter int OW = 8);
  logic start;
  logic in_valid;
  logic [W-1:0] g_input;
  logic [W-1:0] e_input;
  logic [OW-1:0] threshold;
  logic busy;
  logic done;
  logic [OW-1:0] o;
  logic o_ge;
  modport master(output start, in_valid, g_input, e_input, threshold, input busy, done, o, o_ge);
  modport slave(input start, in_valid, g_input, e_input, threshold, output busy, done, o, o_ge);
endinterface

// File: rtl/hamming_seq_acc_popcount_w.sv
// popcount_w: combinational count of set bits; ports d_i (W bits in), cnt_o ($clog2(W+1) bits out)
module popcount_w #(parameter int W = 5, localparam int PW = $clog2(W + 1)) (
  input  logic [W-1:0]  d_i,
  output logic [PW-1:0] cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) cnt_o = cnt_o + PW'(d_i[i]);
  end
endmodule

// File: rtl/hamming_seq_acc.sv
// hamming_seq_acc: W-bit-per-beat Hamming distance accumulator over N bits; ports clk, rst (sync active-low), bus (slave: start/in_valid/g/e/threshold in, busy/done/o/o_ge out)
module hamming_seq_acc import hamming_pkg::*; #(
  parameter int N = 160,
  parameter int W = 5,
  parameter int MODE = MODE_XOR
) (
  input logic clk,
  input logic rst,
  hamming_seq_acc_if.slave bus
);
  localparam int CC = N / W;
  localparam int OW = $clog2(N + 1);
  localparam int CW = cnt_w(CC);
  localparam int PW = $clog2(W + 1);
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [OW-1:0] o_q, thr_q, o_d;
  logic ge_q;
  logic [W-1:0] bits;
  logic [PW-1:0] pc;
  assign bits = MODE == MODE_XNOR ? ~(bus.g_input ^ bus.e_input) : bus.g_input ^ bus.e_input;
  popcount_w #(.W(W)) u_pc (.d_i(bits), .cnt_o(pc));
  assign o_d = o_q + OW'(pc);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      o_q <= '0;
      thr_q <= '0;
      ge_q <= 1'b0;
    end else if (state_q == ACC) begin
      if (bus.in_valid) begin
        o_q <= o_d;
        ge_q <= o_d >= thr_q;
        cnt_q <= cnt_q == CW'(CC - 1) ? '0 : cnt_q + CW'(1);
        if (cnt_q == CW'(CC - 1)) state_q <= DONE;
      end
    end else if (bus.start) begin
      state_q <= ACC;
      cnt_q <= '0;
      o_q <= '0;
      thr_q <= bus.threshold;
    end
  end
  assign bus.busy = state_q == ACC;
  assign bus.done = state_q == DONE;
  assign bus.o = o_q;
  assign bus.o_ge = ge_q;
endmodule

// File: tb/tb_hamming_seq_acc.sv
// tb_hamming_seq_acc: randomized scoreboard bench driving XOR and XNOR engines with shared stimulus
module tb_hamming_seq_acc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, in_valid = 1'b0;
  logic [4:0] g_in = '0, e_in = '0;
  logic [7:0] thr = '0;
  int checks = 0, errors = 0;
  int qo0[$], qg0[$], qo1[$], qg1[$];
  bit pd0 = 0, pd1 = 0;
  always #5 clk = ~clk;
  hamming_seq_acc_if #(.W(5), .OW(8)) b0 ();
  hamming_seq_acc_if #(.W(5), .OW(8)) b1 ();
  assign b0.start = start;
  assign b0.in_valid = in_valid;
  assign b0.g_input = g_in;
  assign b0.e_input = e_in;
  assign b0.threshold = thr;
  assign b1.start = start;
  assign b1.in_valid = in_valid;
  assign b1.g_input = g_in;
  assign b1.e_input = e_in;
  assign b1.threshold = thr;
  hamming_seq_acc #(.N(160), .W(5), .MODE(0)) d0 (.clk(clk), .rst(rst), .bus(b0));
  hamming_seq_acc #(.N(160), .W(5), .MODE(1)) d1 (.clk(clk), .rst(rst), .bus(b1));

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_o0"}, b0.o, 0);
    chk({n, "_o1"}, b1.o, 0);
    chk({n, "_busy"}, b0.busy | b1.busy, 0);
    chk({n, "_done"}, b0.done | b1.done, 0);
    chk({n, "_ge"}, b0.o_ge | b1.o_ge, 0);
  endtask

  always @(negedge clk) begin
    if (b0.done && !pd0) begin
      if (qo0.size() == 0) chk("unexpected_done0", 1, 0);
      else begin
        chk("o_xor", b0.o, qo0.pop_front());
        chk("ge_xor", b0.o_ge, qg0.pop_front());
      end
    end
    if (b1.done && !pd1) begin
      if (qo1.size() == 0) chk("unexpected_done1", 1, 0);
      else begin
        chk("o_xnor", b1.o, qo1.pop_front());
        chk("ge_xnor", b1.o_ge, qg1.pop_front());
      end
    end
    pd0 = b0.done;
    pd1 = b1.done;
  end

  // vmode: 0 always valid, 1 toggling 1,0,1..., 2 random; abort_at>=0 resets after that many beats
  task automatic run(input int t, input int pat, input int vmode, input int abort_at);
    logic [4:0] gq[$], eq[$];
    bit vq[$];
    int e0 = 0, e1 = 0, acc = 0;
    while (acc < 32) begin
      logic [4:0] g, e, x;
      bit v;
      v = vmode == 0 ? 1'b1 : vmode == 1 ? (vq.size() % 2 == 0) : 1'($urandom_range(0, 1));
      g = 5'($urandom);
      e = 5'($urandom);
      if (v) begin
        case (pat)
          0: begin g = 5'h0A; e = 5'h0A; end
          1: begin g = 5'h1F; e = 5'h00; end
          2: e = g ^ (5'b1 << $urandom_range(0, 4));
          3: begin g = 5'h1F; e = 5'h1E; end
          default: ;
        endcase
        acc++;
        x = g ^ e;
        e0 += $countones(x);
        e1 += 5 - $countones(x);
      end
      gq.push_back(g);
      eq.push_back(e);
      vq.push_back(v);
    end
    if (abort_at < 0) begin
      qo0.push_back(e0);
      qg0.push_back(int'(e0 >= t));
      qo1.push_back(e1);
      qg1.push_back(int'(e1 >= t));
    end
    start = 1'b1;
    thr = 8'(t);
    in_valid = 1'b1;
    g_in = 5'h1F;
    e_in = 5'h00;
    cyc();
    chk("start_clear_o0", b0.o, 0);
    chk("start_clear_o1", b1.o, 0);
    chk("start_busy", b0.busy & b1.busy, 1);
    acc = 0;
    foreach (vq[i]) begin
      in_valid = vq[i];
      g_in = gq[i];
      e_in = eq[i];
      start = (i == 5) || ($urandom_range(0, 7) == 0);
      cyc();
      acc += int'(vq[i]);
      if (abort_at >= 0 && acc == abort_at) begin
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        cyc();
        chk_zero("abort");
        rst = 1'b1;
        return;
      end
      if (i == vq.size() - 1) chk("done_latency", b0.done & b1.done, 1);
      else begin
        chk("busy_acc", b0.busy & b1.busy, 1);
        chk("no_early_done", b0.done | b1.done, 0);
      end
    end
    start = 1'b0;
    for (int k = $urandom_range(0, 2); k > 0; k--) begin
      in_valid = 1'($urandom_range(0, 1));
      g_in = 5'($urandom);
      cyc();
      chk("done_hold", b0.done & b1.done, 1);
    end
  endtask

  initial begin
    @(negedge clk);
    cyc();
    cyc();
    chk_zero("reset");
    rst = 1'b1;
    run(0, 0, 0, -1);
    run(160, 1, 0, -1);
    run(159, 1, 0, -1);
    run(0, 2, 1, -1);
    run(0, 1, 0, 10);
    run(160, 1, 0, -1);
    run(129, 3, 0, -1);
    run(128, 3, 0, -1);
    for (int r = 0; r < 6; r++) run($urandom_range(0, 160), 4, 2, -1);
    run(50, 4, 2, 7);
    run(80, 4, 2, -1);
    cyc();
    cyc();
    chk("pending_xor", qo0.size(), 0);
    chk("pending_xnor", qo1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
